// File: rtl/extremum_tracker.sv
// Records peak/valley extrema flagged by the upstream slope stage, tagging each
// with its kind, sample value and distance from the previous extremum, into a 2-deep FIFO.
module extremum_tracker #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] datain,
    input  logic             posen,
    input  logic             negen,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_kind,
    output logic [WIDTH-1:0] out_value,
    output logic [CNTW-1:0]  out_interval,
    output logic             out_first,
    output logic             overflow
);

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_nextState;

    logic [WIDTH-1:0]            r_prevSample;
    logic [CNTW-1:0]             r_interval;

    logic [1:0]                  r_kindMem;
    logic [1:0][WIDTH-1:0]       r_valueMem;
    logic [1:0][CNTW-1:0]        r_intervalMem;
    logic [1:0]                  r_firstMem;
    logic                        r_rdPtr;
    logic                        r_wrPtr;
    logic [1:0]                  r_count;
    logic                        r_overflow;

    logic                        w_event;
    logic                        w_kind;
    logic                        w_recFirst;
    logic [CNTW-1:0]             w_recInterval;
    logic                        w_valid;
    logic                        w_full;
    logic                        w_pop;
    logic                        w_push;
    logic                        w_drop;

    // A simultaneous posen/negen is treated as a peak.
    assign w_event = posen | negen;
    assign w_kind  = posen;

    assign w_valid = (r_count != 2'd0);
    assign w_full  = (r_count == 2'd2);
    assign w_pop   = w_valid & out_ready;
    assign w_push  = w_event & (~w_full | w_pop);
    assign w_drop  = w_event & w_full & ~w_pop;

    always_comb begin
        w_nextState   = r_state;
        w_recFirst    = 1'b0;
        w_recInterval = r_interval;
        case (r_state)
            IDLE: begin
                w_recFirst    = 1'b1;
                w_recInterval = '0;
                if (w_event) begin
                    w_nextState = TRACK;
                end
            end
            TRACK: begin
                w_nextState = TRACK;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_prevSample <= '0;
            r_interval   <= '0;
        end else begin
            r_state      <= w_nextState;
            r_prevSample <= datain;
            if (w_event) begin
                r_interval <= CNTW'(1);
            end else if (r_interval != '1) begin
                r_interval <= r_interval + CNTW'(1);
            end
        end
    end

    // When full with a pop, the write slot equals the slot being popped, so overwriting it is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kindMem     <= '0;
            r_valueMem    <= '0;
            r_intervalMem <= '0;
            r_firstMem    <= '0;
            r_rdPtr       <= 1'b0;
            r_wrPtr       <= 1'b0;
            r_count       <= 2'd0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_push) begin
                r_kindMem[r_wrPtr]     <= w_kind;
                r_valueMem[r_wrPtr]    <= r_prevSample;
                r_intervalMem[r_wrPtr] <= w_recInterval;
                r_firstMem[r_wrPtr]    <= w_recFirst;
                r_wrPtr                <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_valid    = w_valid;
    assign out_kind     = w_valid ? r_kindMem[r_rdPtr]     : 1'b0;
    assign out_value    = w_valid ? r_valueMem[r_rdPtr]    : '0;
    assign out_interval = w_valid ? r_intervalMem[r_rdPtr] : '0;
    assign out_first    = w_valid ? r_firstMem[r_rdPtr]    : 1'b0;
    assign overflow     = r_overflow;

endmodule
